// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: steps the NCO tuning word from a start to a stop value in
// fixed increments, holding each word for a programmable number of cycles.
// Mode 0 runs a single sawtooth ramp; mode 1 bounces continuously between
// the two end points.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; last tuning word held on the output
// UP     | stepping upward toward the stop word
// DOWN   | stepping downward toward the start word (triangle mode only)
module nco_sweep_ctrl #(
  parameter int FW = 10,
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_mode,
  input  logic [FW-1:0] i_f_start,
  input  logic [FW-1:0] i_f_stop,
  input  logic [FW-1:0] i_f_inc,
  input  logic [DW-1:0] i_dwell,
  output logic [FW-1:0] o_freq_step,
  output logic          o_freq_upd,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;

  logic [1:0]    state;
  logic [FW-1:0] f_lo;
  logic [FW-1:0] f_hi;
  logic [FW-1:0] inc_r;
  logic [DW-1:0] dwell_r;
  logic          mode_r;
  logic [DW-1:0] cnt;

  logic [FW-1:0]        inc_n;
  logic [DW-1:0]        dwell_n;
  logic [FW-1:0]        hi_n;
  logic [FW:0]          up_sum;
  logic [FW-1:0]        up_next;
  logic signed [FW:0]   dn_diff;
  logic [FW-1:0]        dn_next;
  logic                 at_hi;
  logic                 at_lo;

  // A zero increment or dwell would stall the sweep, so both are promoted to 1.
  // When stop <= start the upper turn-around collapses onto the start word,
  // which turns the sweep into a single-point hold without special states.
  assign inc_n   = (i_f_inc == '0) ? FW'(1) : i_f_inc;
  assign dwell_n = (i_dwell == '0) ? DW'(1) : i_dwell;
  assign hi_n    = (i_f_stop <= i_f_start) ? i_f_start : i_f_stop;

  // Next words in each direction, computed one bit wider and clamped to the
  // end points so the tuning word can never wrap.
  always_comb begin
    up_sum  = {1'b0, o_freq_step} + {1'b0, inc_r};
    up_next = (up_sum > {1'b0, f_hi}) ? f_hi : up_sum[FW-1:0];
    dn_diff = $signed({1'b0, o_freq_step}) - $signed({1'b0, inc_r});
    dn_next = (dn_diff < $signed({1'b0, f_lo})) ? f_lo : dn_diff[FW-1:0];
    at_hi   = (o_freq_step >= f_hi);
    at_lo   = (o_freq_step <= f_lo);
  end

  // Sweep sequencer: dwell down-counter, tuning-word stepping and status flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      f_lo        <= '0;
      f_hi        <= '0;
      inc_r       <= '0;
      dwell_r     <= '0;
      mode_r      <= 1'b0;
      cnt         <= '0;
      o_freq_step <= '0;
      o_freq_upd  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_freq_upd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start && !i_stop) begin
            f_lo        <= i_f_start;
            f_hi        <= hi_n;
            inc_r       <= inc_n;
            dwell_r     <= dwell_n;
            mode_r      <= i_mode;
            cnt         <= dwell_n - DW'(1);
            o_freq_step <= i_f_start;
            o_freq_upd  <= 1'b1;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
            state       <= S_UP;
          end
        end
        S_UP: begin
          if (i_stop) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - DW'(1);
          end else begin
            cnt <= dwell_r - DW'(1);
            if (!at_hi) begin
              o_freq_step <= up_next;
              o_freq_upd  <= 1'b1;
            end else if (!mode_r) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              // Turn around; a single-point sweep produces no change and no pulse.
              state       <= S_DOWN;
              o_freq_step <= dn_next;
              o_freq_upd  <= (dn_next != o_freq_step);
            end
          end
        end
        S_DOWN: begin
          if (i_stop) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - DW'(1);
          end else begin
            cnt <= dwell_r - DW'(1);
            if (!at_lo) begin
              o_freq_step <= dn_next;
              o_freq_upd  <= 1'b1;
            end else begin
              state       <= S_UP;
              o_freq_step <= up_next;
              o_freq_upd  <= (up_next != o_freq_step);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
module tb_nco_sweep_ctrl;
  localparam int FW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          mode;
  logic [FW-1:0] f_start;
  logic [FW-1:0] f_stop;
  logic [FW-1:0] f_inc;
  logic [DW-1:0] dwell;
  logic [FW-1:0] freq;
  logic          upd;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  int vals[$];
  int times[$];
  int done_at;
  int idle_at;
  int glitches;
  int max_val;

  nco_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_stop     (stop),
    .i_mode     (mode),
    .i_f_start  (f_start),
    .i_f_stop   (f_stop),
    .i_f_inc    (f_inc),
    .i_dwell    (dwell),
    .o_freq_step(freq),
    .o_freq_upd (upd),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #10 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 ns after the edge that sampled the start request.
  task automatic start_sweep(input int fs, input int fe, input int fi, input int dw, input bit md);
    f_start = FW'(fs);
    f_stop  = FW'(fe);
    f_inc   = FW'(fi);
    dwell   = DW'(dw);
    mode    = md;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  // Records every upd-marked word with its cycle offset from the first word.
  task automatic capture(input int budget, input bit until_idle);
    logic [FW-1:0] prev;
    vals.delete();
    times.delete();
    done_at  = -1;
    idle_at  = -1;
    glitches = 0;
    max_val  = 0;
    prev     = freq;
    for (int k = 0; k < budget; k++) begin
      if (upd) begin
        vals.push_back(int'(freq));
        times.push_back(k);
      end else if (freq !== prev) begin
        glitches++;
      end
      prev = freq;
      if (int'(freq) > max_val) max_val = int'(freq);
      if (done && done_at < 0) done_at = k;
      if (!busy && idle_at < 0) idle_at = k;
      if (until_idle && !busy) break;
      step();
    end
  endtask

  function automatic int seq_errors(input int ev[$], input int et[$]);
    int e = 0;
    if (vals.size() != ev.size()) e++;
    for (int i = 0; i < vals.size() && i < ev.size(); i++)
      if (vals[i] != ev[i] || times[i] != et[i]) e++;
    return e;
  endfunction

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    f_start = '0; f_stop = '0; f_inc = '0; dwell = '0;
    #5;
    checks++; if (freq !== '0) begin failures++; $display("FAIL reset_freq: got %0d expected 0", freq); end
    checks++; if (upd !== 1'b0) begin failures++; $display("FAIL reset_upd: got %0b expected 0", upd); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_sawtooth;
    int ev[$];
    int et[$];
    for (int i = 0; i < 15; i++) begin
      ev.push_back(64 + 50 * i);
      et.push_back(5000 * i);
    end
    start_sweep(64, 764, 50, 5000, 1'b0);
    capture(80000, 1'b1);
    checks++; if (seq_errors(ev, et) != 0) begin failures++;
      $display("FAIL saw_seq: got %0d words (%0d mismatches) expected 15 words", vals.size(), seq_errors(ev, et)); end
    checks++; if (done_at != 75000) begin failures++; $display("FAIL saw_done_time: got %0d expected 75000", done_at); end
    checks++; if (idle_at != 75000) begin failures++; $display("FAIL saw_busy_fall: got %0d expected 75000", idle_at); end
    checks++; if (glitches != 0) begin failures++; $display("FAIL saw_silent_change: got %0d expected 0", glitches); end
  endtask

  task automatic test_clamp;
    start_sweep(100, 230, 50, 2, 1'b0);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL clamp_done_clear: got %0b expected 0", done); end
    capture(50, 1'b1);
    checks++; if (seq_errors('{100, 150, 200, 230}, '{0, 2, 4, 6}) != 0) begin failures++;
      $display("FAIL clamp_seq: got %0d words expected 4", vals.size()); end
    checks++; if (done_at != 8) begin failures++; $display("FAIL clamp_done_time: got %0d expected 8", done_at); end
    checks++; if (max_val > 230) begin failures++; $display("FAIL clamp_max: got %0d expected <=230", max_val); end
  endtask

  task automatic test_overflow;
    start_sweep(1000, 1023, 100, 1, 1'b0);
    capture(50, 1'b1);
    checks++; if (seq_errors('{1000, 1023}, '{0, 1}) != 0) begin failures++;
      $display("FAIL ovf_seq: got %0d words expected 2", vals.size()); end
    checks++; if (done_at != 2) begin failures++; $display("FAIL ovf_done_time: got %0d expected 2", done_at); end
    checks++; if (freq !== 10'd1023) begin failures++; $display("FAIL ovf_final: got %0d expected 1023", freq); end
  endtask

  task automatic test_triangle;
    int ev[$];
    int et[$];
    int pat[6];
    int frozen_bad;
    pat = '{10, 20, 30, 40, 30, 20};
    for (int i = 0; i < 14; i++) begin
      ev.push_back(pat[i % 6]);
      et.push_back(3 * i);
    end
    start_sweep(10, 40, 10, 3, 1'b1);
    capture(40, 1'b0);
    checks++; if (seq_errors(ev, et) != 0) begin failures++;
      $display("FAIL tri_seq: got %0d words (%0d mismatches) expected 14", vals.size(), seq_errors(ev, et)); end
    checks++; if (done_at != -1) begin failures++; $display("FAIL tri_no_done: got done at %0d expected never", done_at); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tri_stop_busy: got %0b expected 0", busy); end
    checks++; if (freq !== 10'd20) begin failures++; $display("FAIL tri_stop_freq: got %0d expected 20", freq); end
    frozen_bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (freq !== 10'd20 || upd !== 1'b0 || done !== 1'b0) frozen_bad++;
    end
    checks++; if (frozen_bad != 0) begin failures++; $display("FAIL tri_frozen: got %0d bad cycles expected 0", frozen_bad); end
  endtask

  task automatic test_stop_priority;
    start_sweep(10, 40, 10, 3, 1'b1);
    repeat (5) step();
    checks++; if (freq !== 10'd20) begin failures++; $display("FAIL prio_pre: got %0d expected 20", freq); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (freq !== 10'd20 || upd !== 1'b0 || busy !== 1'b0) begin failures++;
      $display("FAIL prio_no_step: got freq=%0d upd=%0b busy=%0b expected 20/0/0", freq, upd, busy); end
  endtask

  task automatic test_corner_norm;
    start_sweep(5, 8, 0, 0, 1'b0);
    capture(20, 1'b1);
    checks++; if (seq_errors('{5, 6, 7, 8}, '{0, 1, 2, 3}) != 0) begin failures++;
      $display("FAIL norm_seq: got %0d words expected 4", vals.size()); end
    checks++; if (done_at != 4) begin failures++; $display("FAIL norm_done_time: got %0d expected 4", done_at); end
  endtask

  task automatic test_single_point;
    start_sweep(7, 7, 3, 1, 1'b0);
    capture(20, 1'b1);
    checks++; if (seq_errors('{7}, '{0}) != 0) begin failures++;
      $display("FAIL single_seq: got %0d words expected 1", vals.size()); end
    checks++; if (done_at != 1) begin failures++; $display("FAIL single_done_time: got %0d expected 1", done_at); end
    start_sweep(9, 3, 4, 2, 1'b1);
    capture(20, 1'b0);
    checks++; if (seq_errors('{9}, '{0}) != 0 || glitches != 0) begin failures++;
      $display("FAIL degen_hold: got %0d words, %0d silent changes expected 1/0", vals.size(), glitches); end
    checks++; if (busy !== 1'b1 || done_at != -1) begin failures++;
      $display("FAIL degen_busy: got busy=%0b done_at=%0d expected 1/-1", busy, done_at); end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_start_stop_idle;
    start_sweep(5, 8, 1, 1, 1'b0);
    capture(20, 1'b1);
    f_start = 10'd300; f_stop = 10'd400; f_inc = 10'd10; dwell = 16'd2;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    checks++; if (busy !== 1'b0 || upd !== 1'b0) begin failures++;
      $display("FAIL both_no_start: got busy=%0b upd=%0b expected 0/0", busy, upd); end
    step();
    checks++; if (freq !== 10'd8 || done !== 1'b1) begin failures++;
      $display("FAIL both_hold: got freq=%0d done=%0b expected 8/1", freq, done); end
  endtask

  task automatic test_reset_mid_sweep;
    start_sweep(64, 764, 50, 4, 1'b0);
    repeat (6) step();
    #4;
    rst = 1'b1;
    #1;
    checks++; if (freq !== '0 || upd !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++;
      $display("FAIL async_rst: got freq=%0d upd=%0b busy=%0b done=%0b expected all 0", freq, upd, busy, done); end
    #3;
    rst = 1'b0;
    step();
  endtask

  task automatic test_ignore_busy;
    start_sweep(20, 50, 10, 2, 1'b0);
    f_start = 10'd500; f_stop = 10'd900; f_inc = 10'd1; dwell = 16'd7; mode = 1'b1;
    start = 1'b1;
    capture(30, 1'b1);
    start = 1'b0;
    checks++; if (seq_errors('{20, 30, 40, 50}, '{0, 2, 4, 6}) != 0) begin failures++;
      $display("FAIL busy_ignore_seq: got %0d words expected 4", vals.size()); end
    checks++; if (done_at != 8 || idle_at != 8) begin failures++;
      $display("FAIL busy_ignore_done: got done=%0d idle=%0d expected 8/8", done_at, idle_at); end
    step();
    checks++; if (busy !== 1'b0 || freq !== 10'd50) begin failures++;
      $display("FAIL busy_ignore_idle: got busy=%0b freq=%0d expected 0/50", busy, freq); end
  endtask

  initial begin
    test_reset();
    test_sawtooth();
    test_clamp();
    test_overflow();
    test_triangle();
    test_stop_priority();
    test_corner_norm();
    test_single_point();
    test_start_stop_idle();
    test_reset_mid_sweep();
    test_ignore_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
